sim_run_ctrl: RTL and testbench

Parametrised run controller for the simulation top, instantiated alongside mercury_top.
- Sequences core reset.
- Counts cycles and retired instructions over NUM_RET retire channels.
- Gates the waveform dump window.
- Terminates the run on a tohost exit write, a retire-hang watchdog, or a global timeout.
- Reports a sticky final status the bench uses to call $finish and print the result.

---
 rtl/sim_pkg.sv | 19 +
 rtl/sim_run_ctrl_if.sv | 29 ++
 rtl/sim_sat_cnt.sv | 33 +++
 rtl/sim_run_ctrl.sv | 120 ++++++++++++
 tb/tb_sim_run_ctrl.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sim_pkg.sv
// Shared state encoding and helpers for the simulation run controller.
package sim_pkg;

    typedef enum logic [2:0] {
        S_RESET   = 3'd0,
        S_RUN     = 3'd1,
        S_PASS    = 3'd2,
        S_FAIL    = 3'd3,
        S_TIMEOUT = 3'd4,
        S_HANG    = 3'd5
    } sim_state_e;

    localparam int TOHOST_EXIT_BIT = 0;

    function automatic logic is_terminal(input sim_state_e s);
        return (s == S_PASS) || (s == S_FAIL) || (s == S_TIMEOUT) || (s == S_HANG);
    endfunction

endpackage

// File: rtl/sim_run_ctrl_if.sv
// Core-side bundle of the run controller: retire/tohost inputs and run status outputs.
interface sim_run_ctrl_if #(
    parameter int NUM_RET = 2,
    parameter int CNT_W   = 32
);
    import sim_pkg::*;

    logic [NUM_RET-1:0] ret_valid;
    logic               tohost_valid;
    logic [31:0]        tohost_data;
    logic               core_rst;
    logic               dump_en;
    logic               done;
    sim_state_e         status;
    logic [30:0]        exit_code;
    logic [CNT_W-1:0]   cycle_cnt;
    logic [CNT_W-1:0]   inst_cnt;

    modport master (
        output ret_valid, tohost_valid, tohost_data,
        input  core_rst, dump_en, done, status, exit_code, cycle_cnt, inst_cnt
    );

    modport slave (
        input  ret_valid, tohost_valid, tohost_data,
        output core_rst, dump_en, done, status, exit_code, cycle_cnt, inst_cnt
    );

endinterface

// File: rtl/sim_sat_cnt.sv
// Saturating accumulator: adds inc when enabled, sticks at all-ones, clear wins over enable.
module sim_sat_cnt #(
    parameter int W     = 32,
    parameter int INC_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [INC_W-1:0] inc,
    output logic [W-1:0]     cnt
);

    localparam int SUM_W = ((W > INC_W) ? W : INC_W) + 1;

    function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [INC_W-1:0] b);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(b);
        if (|s[SUM_W-1:W])
            return {W{1'b1}};
        return s[W-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= sat_add(cnt, inc);
    end

endmodule

// File: rtl/sim_run_ctrl.sv
// Run controller: sequences core reset, counts cycles/retires, gates the dump window
// and latches a sticky terminal status on exit, hang or timeout.
module sim_run_ctrl
    import sim_pkg::*;
#(
    parameter int NUM_RET     = 2,
    parameter int CNT_W       = 32,
    parameter int RST_CYCLES  = 4,
    parameter int TIMEOUT     = 1000,
    parameter int HANG_CYCLES = 256,
    parameter int DUMP_START  = 0,
    parameter int DUMP_STOP   = 1000
) (
    input logic           clk,
    input logic           rst,
    sim_run_ctrl_if.slave bus
);

    localparam int POP_W  = $clog2(NUM_RET + 1);
    localparam int HANG_W = (HANG_CYCLES > 1) ? $clog2(HANG_CYCLES) : 1;
    localparam int RST_W  = $clog2(RST_CYCLES + 1);

    if (RST_CYCLES < 1 || TIMEOUT < 1 || NUM_RET < 1) begin : g_bad_min
        $error("sim_run_ctrl: RST_CYCLES, TIMEOUT and NUM_RET must all be >= 1");
    end
    if (CNT_W < 31 && TIMEOUT >= (1 << CNT_W)) begin : g_bad_timeout
        $error("sim_run_ctrl: TIMEOUT does not fit in CNT_W bits");
    end

    sim_state_e       state, nxt_state;
    logic [RST_W-1:0] rst_cnt;
    logic [CNT_W-1:0] cycle_cnt, inst_cnt, nxt_cycle;
    logic [HANG_W-1:0] hang_cnt;
    logic [30:0]      exit_code;
    logic             core_rst, dump_en;
    logic             run, any_ret, exit_hit, hang_hit, tmo_hit;

    function automatic logic [POP_W-1:0] popcount(input logic [NUM_RET-1:0] v);
        logic [POP_W-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_RET; i++)
            c = c + POP_W'(v[i]);
        return c;
    endfunction

    // Compared in 64 bits so windows wider than CNT_W behave as "open ended".
    function automatic logic in_dump_window(input logic [CNT_W-1:0] c);
        logic [63:0] cw;
        cw = 64'(c);
        return (cw >= 64'(DUMP_START)) && (cw < 64'(DUMP_STOP));
    endfunction

    always_comb begin
        run       = (state == S_RUN);
        any_ret   = |bus.ret_valid;
        exit_hit  = bus.tohost_valid && bus.tohost_data[TOHOST_EXIT_BIT];
        hang_hit  = (HANG_CYCLES != 0) && !any_ret && (hang_cnt == HANG_W'(HANG_CYCLES - 1));
        tmo_hit   = (cycle_cnt == CNT_W'(TIMEOUT - 1));
        nxt_state = state;
        nxt_cycle = cycle_cnt;
        case (state)
            S_RESET: begin
                if (rst_cnt == RST_W'(RST_CYCLES - 1))
                    nxt_state = S_RUN;
            end
            S_RUN: begin
                nxt_cycle = cycle_cnt + CNT_W'(1);
                if (exit_hit)
                    nxt_state = (bus.tohost_data[31:1] == 31'd0) ? S_PASS : S_FAIL;
                else if (hang_hit)
                    nxt_state = S_HANG;
                else if (tmo_hit)
                    nxt_state = S_TIMEOUT;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_RESET;
            rst_cnt   <= '0;
            core_rst  <= 1'b1;
            dump_en   <= 1'b0;
            exit_code <= '0;
        end else begin
            state   <= nxt_state;
            dump_en <= (nxt_state == S_RUN) && in_dump_window(nxt_cycle);
            if (state == S_RESET) begin
                rst_cnt <= rst_cnt + RST_W'(1);
                if (nxt_state == S_RUN)
                    core_rst <= 1'b0;
            end
            if (run && exit_hit)
                exit_code <= bus.tohost_data[31:1];
        end
    end

    sim_sat_cnt #(.W(CNT_W), .INC_W(1)) u_cycle_cnt (
        .clk(clk), .rst(rst), .clr(1'b0), .en(run), .inc(1'b1), .cnt(cycle_cnt)
    );

    sim_sat_cnt #(.W(CNT_W), .INC_W(POP_W)) u_inst_cnt (
        .clk(clk), .rst(rst), .clr(1'b0), .en(run), .inc(popcount(bus.ret_valid)), .cnt(inst_cnt)
    );

    // Counts consecutive idle RUN cycles; any retire restarts the count.
    sim_sat_cnt #(.W(HANG_W), .INC_W(1)) u_hang_cnt (
        .clk(clk), .rst(rst), .clr(run && any_ret), .en(run), .inc(1'b1), .cnt(hang_cnt)
    );

    assign bus.core_rst  = core_rst;
    assign bus.dump_en   = dump_en;
    assign bus.done      = is_terminal(state);
    assign bus.status    = state;
    assign bus.exit_code = exit_code;
    assign bus.cycle_cnt = cycle_cnt;
    assign bus.inst_cnt  = inst_cnt;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Randomised bench for sim_run_ctrl: three parameterisations share stimulus and are
// compared every cycle against a behavioural run model, plus directed literal checks.
module tb_sim_run_ctrl;
    import sim_pkg::*;

    localparam int ND = 3;
    localparam int C_W[ND]    = '{32, 4, 32};
    localparam int C_RST[ND]  = '{4, 2, 4};
    localparam int C_TMO[ND]  = '{50, 15, 1000};
    localparam int C_HANG[ND] = '{8, 0, 256};
    localparam int C_DS[ND]   = '{10, 9, 0};
    localparam int C_DE[ND]   = '{20, 5, 1000};

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  ret;
    logic        tv;
    logic [31:0] td;
    logic        cmp_on = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    sim_run_ctrl_if #(.NUM_RET(2), .CNT_W(32)) if0 ();
    sim_run_ctrl_if #(.NUM_RET(2), .CNT_W(4))  if1 ();
    sim_run_ctrl_if #(.NUM_RET(2), .CNT_W(32)) if2 ();

    assign if0.ret_valid = ret; assign if0.tohost_valid = tv; assign if0.tohost_data = td;
    assign if1.ret_valid = ret; assign if1.tohost_valid = tv; assign if1.tohost_data = td;
    assign if2.ret_valid = ret; assign if2.tohost_valid = tv; assign if2.tohost_data = td;

    sim_run_ctrl #(.NUM_RET(2), .CNT_W(32), .RST_CYCLES(4), .TIMEOUT(50), .HANG_CYCLES(8),
                   .DUMP_START(10), .DUMP_STOP(20)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    sim_run_ctrl #(.NUM_RET(2), .CNT_W(4), .RST_CYCLES(2), .TIMEOUT(15), .HANG_CYCLES(0),
                   .DUMP_START(9), .DUMP_STOP(5)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
    sim_run_ctrl #(.NUM_RET(2), .CNT_W(32), .RST_CYCLES(4), .TIMEOUT(1000), .HANG_CYCLES(256),
                   .DUMP_START(0), .DUMP_STOP(1000)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

    logic        o_core[ND], o_dump[ND], o_done[ND];
    logic [2:0]  o_st[ND];
    logic [30:0] o_exit[ND];
    logic [31:0] o_cyc[ND], o_inst[ND];

    assign o_core[0] = if0.core_rst; assign o_dump[0] = if0.dump_en; assign o_done[0] = if0.done;
    assign o_st[0] = if0.status; assign o_exit[0] = if0.exit_code;
    assign o_cyc[0] = if0.cycle_cnt; assign o_inst[0] = if0.inst_cnt;
    assign o_core[1] = if1.core_rst; assign o_dump[1] = if1.dump_en; assign o_done[1] = if1.done;
    assign o_st[1] = if1.status; assign o_exit[1] = if1.exit_code;
    assign o_cyc[1] = {28'd0, if1.cycle_cnt}; assign o_inst[1] = {28'd0, if1.inst_cnt};
    assign o_core[2] = if2.core_rst; assign o_dump[2] = if2.dump_en; assign o_done[2] = if2.done;
    assign o_st[2] = if2.status; assign o_exit[2] = if2.exit_code;
    assign o_cyc[2] = if2.cycle_cnt; assign o_inst[2] = if2.inst_cnt;

    // Behavioural model: phase 0 reset, 1 run, 2..5 terminal outcomes.
    int          m_phase[ND];
    int          m_rcnt[ND];
    int          m_idle[ND];
    longint      m_cyc[ND], m_inst[ND];
    logic        m_core[ND], m_dump[ND];
    logic [30:0] m_exit[ND];

    function automatic logic win(input int d, input longint c);
        return (c >= C_DS[d]) && (c < C_DE[d]);
    endfunction

    task automatic model_reset(input int d);
        m_phase[d] = 0; m_rcnt[d] = 0; m_idle[d] = 0;
        m_cyc[d] = 0; m_inst[d] = 0; m_core[d] = 1'b1; m_dump[d] = 1'b0; m_exit[d] = '0;
    endtask

    task automatic model_step(input int d);
        longint maxv = (64'sd1 <<< C_W[d]) - 1;
        longint prev;
        int     n = $countones(ret);
        if (m_phase[d] == 0) begin
            m_rcnt[d]++;
            if (m_rcnt[d] == C_RST[d]) begin
                m_phase[d] = 1; m_core[d] = 1'b0; m_dump[d] = win(d, 0);
            end
        end else if (m_phase[d] == 1) begin
            prev = m_cyc[d];
            m_cyc[d] = prev + 1;
            m_inst[d] = (m_inst[d] + n > maxv) ? maxv : m_inst[d] + n;
            m_idle[d] = (n > 0) ? 0 : m_idle[d] + 1;
            if (tv && td[0]) begin
                m_exit[d] = td[31:1];
                m_phase[d] = (td[31:1] == 31'd0) ? 2 : 3;
            end else if (C_HANG[d] != 0 && m_idle[d] == C_HANG[d])
                m_phase[d] = 5;
            else if (prev == C_TMO[d] - 1)
                m_phase[d] = 4;
            m_dump[d] = (m_phase[d] == 1) && win(d, m_cyc[d]);
        end
    endtask

    always @(posedge clk or negedge rst) begin
        for (int d = 0; d < ND; d++)
            if (!rst) model_reset(d); else model_step(d);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            for (int d = 0; d < ND; d++) begin
                chk($sformatf("d%0d.core_rst", d), 64'(o_core[d]), 64'(m_core[d]));
                chk($sformatf("d%0d.dump_en", d),  64'(o_dump[d]), 64'(m_dump[d]));
                chk($sformatf("d%0d.done", d),     64'(o_done[d]), 64'(m_phase[d] >= 2));
                chk($sformatf("d%0d.status", d),   64'(o_st[d]),   64'(m_phase[d]));
                chk($sformatf("d%0d.exit_code", d), 64'(o_exit[d]), 64'(m_exit[d]));
                chk($sformatf("d%0d.cycle_cnt", d), 64'(o_cyc[d]), 64'(m_cyc[d]));
                chk($sformatf("d%0d.inst_cnt", d),  64'(o_inst[d]), 64'(m_inst[d]));
            end
        end
    end

    // Leaves the bench at the negedge inside RUN cycle 0 of the RST_CYCLES=4 instances.
    task automatic rst_pulse();
        @(negedge clk);
        #2 rst = 1'b0; ret = '0; tv = 1'b0; td = '0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk($sformatf("rst.edge%0d.d0.core_rst", k), 64'(o_core[0]), 64'(k < 4));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic idle;
        rst = 1'b0; ret = '0; tv = 1'b0; td = '0;
        for (int d = 0; d < ND; d++) model_reset(d);
        repeat (2) @(negedge clk);
        cmp_on = 1'b1;

        // Reset sequence and pass exit
        rst_pulse();
        chk("rst.d2.status", 64'(o_st[2]), 64'(1));
        chk("rst.d2.dump_en", 64'(o_dump[2]), 64'(1));
        chk("rst.d0.dump_en", 64'(o_dump[0]), 64'(0));
        ret = 2'b11;
        for (int k = 0; k < 20; k++) begin
            chk("pass.d2.cycle_cnt", 64'(o_cyc[2]), 64'(k));
            @(negedge clk);
        end
        tv = 1'b1; td = 32'h1;
        @(negedge clk);
        tv = 1'b0;
        chk("pass.d2.status", 64'(o_st[2]), 64'(2));
        chk("pass.d2.done", 64'(o_done[2]), 64'(1));
        chk("pass.d2.exit_code", 64'(o_exit[2]), 64'(0));
        chk("pass.d2.inst_cnt", 64'(o_inst[2]), 64'(42));
        chk("pass.d2.cycle_cnt", 64'(o_cyc[2]), 64'(21));
        chk("sat.d1.inst_cnt", 64'(o_inst[1]), 64'(15));
        chk("sat.d1.status", 64'(o_st[1]), 64'(4));
        tv = 1'b1; td = 32'h7;
        @(negedge clk);
        tv = 1'b0;
        repeat (4) @(negedge clk);
        chk("frozen.d2.status", 64'(o_st[2]), 64'(2));
        chk("frozen.d2.inst_cnt", 64'(o_inst[2]), 64'(42));
        chk("frozen.d2.cycle_cnt", 64'(o_cyc[2]), 64'(21));
        chk("frozen.d2.core_rst", 64'(o_core[2]), 64'(0));

        // Fail exit beats a simultaneous hang
        rst_pulse();
        ret = 2'b00;
        repeat (7) @(negedge clk);
        tv = 1'b1; td = 32'h0000_0007;
        @(negedge clk);
        tv = 1'b0;
        chk("fail.d0.status", 64'(o_st[0]), 64'(3));
        chk("fail.d0.exit_code", 64'(o_exit[0]), 64'(3));
        chk("fail.d0.cycle_cnt", 64'(o_cyc[0]), 64'(8));
        chk("fail.d2.status", 64'(o_st[2]), 64'(3));

        // Hang after 8 idle cycles; console write ignored
        rst_pulse();
        ret = 2'b11;
        repeat (10) @(negedge clk);
        ret = 2'b00;
        repeat (2) @(negedge clk);
        tv = 1'b1; td = 32'h0;
        @(negedge clk);
        tv = 1'b0;
        repeat (4) @(negedge clk);
        chk("hang.c17.d0.status", 64'(o_st[0]), 64'(1));
        @(negedge clk);
        chk("hang.d0.status", 64'(o_st[0]), 64'(5));
        chk("hang.d0.cycle_cnt", 64'(o_cyc[0]), 64'(18));
        chk("hang.d0.inst_cnt", 64'(o_inst[0]), 64'(20));
        chk("hang.d2.status", 64'(o_st[2]), 64'(1));

        // Timeout and dump window
        rst_pulse();
        ret = 2'b01;
        for (int k = 0; k < 50; k++) begin
            chk("win.d0.dump_en", 64'(o_dump[0]), 64'(k >= 10 && k < 20));
            chk("win.d0.cycle_cnt", 64'(o_cyc[0]), 64'(k));
            @(negedge clk);
        end
        chk("tmo.d0.status", 64'(o_st[0]), 64'(4));
        chk("tmo.d0.cycle_cnt", 64'(o_cyc[0]), 64'(50));
        chk("tmo.d0.dump_en", 64'(o_dump[0]), 64'(0));

        // Asynchronous reset mid-run
        rst_pulse();
        for (int k = 0; k < 30; k++) begin
            ret = 2'($urandom_range(1, 3));
            @(negedge clk);
        end
        #2 rst = 1'b0;
        #1;
        chk("mid.d0.core_rst", 64'(o_core[0]), 64'(1));
        chk("mid.d0.status", 64'(o_st[0]), 64'(0));
        chk("mid.d0.cycle_cnt", 64'(o_cyc[0]), 64'(0));
        chk("mid.d2.inst_cnt", 64'(o_inst[2]), 64'(0));
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("rerun.d0.status", 64'(o_st[0]), 64'(1));
        chk("rerun.d0.cycle_cnt", 64'(o_cyc[0]), 64'(0));
        @(negedge clk);
        chk("rerun.d0.cycle_cnt1", 64'(o_cyc[0]), 64'(1));

        // Long run to the default-style timeout
        rst_pulse();
        ret = 2'b10;
        repeat (1002) @(negedge clk);
        chk("tmo.d2.status", 64'(o_st[2]), 64'(4));
        chk("tmo.d2.cycle_cnt", 64'(o_cyc[2]), 64'(1000));
        chk("tmo.d2.inst_cnt", 64'(o_inst[2]), 64'(1000));

        // Randomised runs
        for (int r = 0; r < 8; r++) begin
            rst_pulse();
            idle = 1'b0;
            for (int c = 0; c < int'($urandom_range(40, 300)); c++) begin
                if ($urandom_range(0, 29) == 0) idle = ~idle;
                ret = idle ? 2'b00 : 2'($urandom);
                tv = 1'b0; td = 32'($urandom);
                if ($urandom_range(0, 59) == 0) begin
                    tv = 1'b1; td[0] = 1'b0;
                end else if ($urandom_range(0, 149) == 0) begin
                    tv = 1'b1; td[0] = 1'b1;
                    if ($urandom_range(0, 1) == 0) td[31:1] = '0;
                end
                if ($urandom_range(0, 199) == 0) begin
                    #2 rst = 1'b0;
                    repeat ($urandom_range(1, 3)) @(negedge clk);
                    #2 rst = 1'b1;
                end
                @(negedge clk);
            end
            tv = 1'b0;
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
